// File: rtl/multi_op_seq_pkg.sv
// Shared definitions for the multi-operation sequencer: op encodings and FSM states.
package multi_op_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multi_op.sv
// Combinational arithmetic core: add, sub, mul, or multiply-accumulate on signed
// operands, wrapping modulo 2^(N+M+2).
module multi_op
  import multi_op_seq_pkg::*;
#(
  parameter int N = 64,
  parameter int M = 64
) (
  input  logic signed [N-1:0]     a_i,
  input  logic signed [M-1:0]     b_i,
  input  logic signed [N+M+1:0]   c_i,
  input  logic                    s0_i,
  input  logic                    s1_i,
  output logic signed [N+M+1:0]   r_o
);

  logic signed [N+M+1:0] a_x;
  logic signed [N+M+1:0] b_x;
  logic signed [N+M+1:0] prod;

  // Full-width sign extension first, so every op wraps at the result width.
  assign a_x  = {{(M+2){a_i[N-1]}}, a_i};
  assign b_x  = {{(N+2){b_i[M-1]}}, b_i};
  assign prod = a_x * b_x;

  always_comb begin
    r_o = '0;
    case (op_e'({s1_i, s0_i}))
      OP_ADD:  r_o = a_x + b_x;
      OP_SUB:  r_o = a_x - b_x;
      OP_MUL:  r_o = prod;
      OP_MAC:  r_o = c_i + prod;
      default: r_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_op_seq.sv
// Command sequencer around the multi_op core: accept a command, execute it in one
// cycle, then hold the registered result until the consumer takes it.
module multi_op_seq
  import multi_op_seq_pkg::*;
#(
  parameter int N = 64,
  parameter int M = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              op,
  input  logic                    acc_clr,
  input  logic signed [N-1:0]     a,
  input  logic signed [M-1:0]     b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [N+M+1:0]   y,
  output logic signed [N+M+1:0]   acc,
  output logic [15:0]             op_cnt
);

  state_e                state_q;
  op_e                   op_q;
  logic                  clr_q;
  logic signed [N-1:0]   a_q;
  logic signed [M-1:0]   b_q;
  logic signed [N+M+1:0] y_q;
  logic signed [N+M+1:0] acc_q;
  logic [15:0]           cnt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic signed [N+M+1:0] core_c;
  logic signed [N+M+1:0] core_r;

  assign core_c = clr_q ? '0 : acc_q;

  multi_op #(.N(N), .M(M)) u_core (
    .a_i  (a_q),
    .b_i  (b_q),
    .c_i  (core_c),
    .s0_i (op_q[0]),
    .s1_i (op_q[1]),
    .r_o  (core_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      clr_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= op_e'(op);
            clr_q      <= acc_clr;
            a_q        <= a;
            b_q        <= b;
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          y_q <= core_r;
          // The accumulator follows only mac results; other ops may just clear it.
          if (op_q == OP_MAC) begin
            acc_q <= core_r;
          end else if (clr_q) begin
            acc_q <= '0;
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= cnt_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign acc       = acc_q;
  assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_multi_op_seq.sv
// Scoreboard bench for multi_op_seq at N=M=8: directed scenarios plus random commands.
module tb_multi_op_seq;

  localparam int N = 8;
  localparam int M = 8;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            op;
  logic                  acc_clr;
  logic signed [N-1:0]   a;
  logic signed [M-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [N+M+1:0] y;
  logic signed [N+M+1:0] acc;
  logic [15:0]           op_cnt;

  multi_op_seq #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc_clr   (acc_clr),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .acc       (acc),
    .op_cnt    (op_cnt)
  );

  typedef struct {
    logic [17:0] y;
    logic [17:0] acc;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  longint      m_acc  = 0;
  logic [15:0] m_cnt  = '0;
  bit          rand_bp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic longint wrap18(input longint v);
    logic [17:0] t;
    t = v[17:0];
    return longint'($signed(t));
  endfunction

  // Reference: plain integer arithmetic, then reduce to the 18-bit result width.
  task automatic issue(input logic [1:0] o, input logic c,
                       input logic signed [7:0] aa, input logic signed [7:0] bb);
    int     n;
    longint av, bv, cv, r;
    exp_t   e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout_in_ready", 0, 1);
      return;
    end
    in_valid = 1'b1; op = o; acc_clr = c; a = aa; b = bb;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    av = longint'(aa);
    bv = longint'(bb);
    cv = c ? 0 : m_acc;
    case (o)
      2'b00:   r = av + bv;
      2'b01:   r = av - bv;
      2'b10:   r = av * bv;
      default: r = cv + av * bv;
    endcase
    r = wrap18(r);
    if (o == 2'b11) m_acc = r;
    else if (c) m_acc = 0;
    e.y   = r[17:0];
    e.acc = m_acc[17:0];
    e.cnt = m_cnt;
    e.cyc = cyc;
    m_cnt = m_cnt + 16'd1;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    op = 2'($urandom);
    acc_clr = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      out_ready = 1'b1;
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    bit   seen;
    exp_t e;
    int   n;

    rst = 1'b1; in_valid = 1'b0; op = 2'b00; acc_clr = 1'b0;
    a = '0; b = '0; out_ready = 1'b1;

    fork
      begin
        seen = 0;
        forever begin
          @(negedge clk);
          if (!rst && out_valid && !seen) begin
            if (sb_q.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_result: out_valid with y=%0h, required no result", y);
            end else begin
              e = sb_q[0];
              chk("latency", cyc - e.cyc, 2);
              chk("y", longint'(y[17:0]), longint'(e.y));
              chk("acc", longint'(acc[17:0]), longint'(e.acc));
              chk("op_cnt", longint'(op_cnt), longint'(e.cnt));
            end
            seen = 1;
          end
          @(posedge clk);
          if (rst) seen = 0;
          else if (out_valid && out_ready) begin
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            seen = 0;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_acc", acc, 0);
    chk("rst_op_cnt", op_cnt, 0);

    // Add, then sub and mul with extreme operands.
    issue(2'b00, 1'b0, 8'sd5, -8'sd3);
    drain();
    chk("add_op_cnt", op_cnt, 1);
    chk("add_y", y, 2);
    issue(2'b01, 1'b0, -8'sd128, 8'sd127);
    drain();
    chk("sub_y", y, -255);
    issue(2'b10, 1'b0, -8'sd128, -8'sd128);
    drain();
    chk("mul_y", y, 16384);
    chk("mul_acc", acc, 0);

    // MAC chain.
    issue(2'b11, 1'b1, 8'sd3, 8'sd4);
    drain();
    chk("mac1_acc", acc, 12);
    issue(2'b11, 1'b0, -8'sd2, 8'sd5);
    drain();
    chk("mac2_y", y, 2);
    chk("mac2_acc", acc, 2);

    // Backpressure with an ignored in_valid pulse.
    out_ready = 1'b0;
    issue(2'b00, 1'b0, 8'sd10, 8'sd20);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_y_held", y, 30);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      if (i == 1) begin in_valid = 1'b1; op = 2'b10; a = 8'sd7; b = 8'sd7; end
      if (i == 2) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_y", y, 30);
    drain();

    // Reset during EXEC abandons the command.
    issue(2'b11, 1'b1, 8'sd3, 8'sd4);
    drain();
    chk("pre_rst_acc", acc, 12);
    @(negedge clk);
    in_valid = 1'b1; op = 2'b11; acc_clr = 1'b0; a = 8'sd1; b = 8'sd1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("exec_in_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_acc", acc, 0);
    chk("midrst_y", y, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_op_cnt", op_cnt, 0);
    m_acc = 0;
    m_cnt = '0;
    repeat (4) @(negedge clk);
    chk("midrst_no_result", out_valid, 0);

    // Random commands with random consumer stalls.
    rand_bp = 1;
    for (int k = 0; k < 40; k++) begin
      issue(2'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom));
    end
    rand_bp = 0;
    drain();
    chk("final_op_cnt", op_cnt, m_cnt);
    chk("final_acc", longint'(acc[17:0]), longint'(m_acc[17:0]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
